// File: rtl/dca_lsu_read_arbiter.sv
// Round-robin arbiter sharing one LSU read port among NUM_REQ load units; zero-cycle request path,
// in-order ID FIFO routes responses back; a stalled grant is locked until accepted, a full FIFO blocks grants.
module dca_lsu_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_BURDEN       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [NUM_REQ-1:0]           s_req_valid,
  output logic [NUM_REQ-1:0]           s_req_ready,
  input  logic [NUM_REQ*BW_ADDR-1:0]   s_req_addr,
  output logic [NUM_REQ-1:0]           s_resp_valid,
  input  logic [NUM_REQ-1:0]           s_resp_ready,
  output logic [BW_DATA-1:0]           s_resp_data,
  output logic                         s_resp_last,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [BW_ADDR-1:0]           m_req_addr,
  input  logic                         m_resp_valid,
  output logic                         m_resp_ready,
  input  logic [BW_DATA+BW_BURDEN-1:0] m_resp_ydata,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;
  logic           lock;
  logic [IDW-1:0] grant;
  logic           any_cand;
  logic [IDW:0]   idx_sum;
  logic [IDW-1:0] idx_wrap;
  logic [IDW-1:0] grant_next;

  logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic [IDW-1:0] head;

  logic flush;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic last;

  assign flush      = rst | clear;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(MAX_OUTSTANDING));
  assign head       = id_mem[rd_ptr];
  assign last       = m_resp_ydata[BW_DATA+BW_BURDEN-1];

  // Locked grant wins while its requester still asserts valid; otherwise first valid from rr_ptr upward.
  always_comb begin
    grant    = '0;
    any_cand = 1'b0;
    idx_sum  = '0;
    idx_wrap = '0;
    if (lock && s_req_valid[lock_id]) begin
      grant    = lock_id;
      any_cand = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx_sum  = {1'b0, rr_ptr} + (IDW+1)'(k);
        idx_wrap = (idx_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(idx_sum - (IDW+1)'(NUM_REQ))
                                                   : idx_sum[IDW-1:0];
        if (s_req_valid[idx_wrap]) begin
          grant    = idx_wrap;
          any_cand = 1'b1;
        end
      end
    end
  end

  assign grant_next = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    s_req_ready  = '0;
    s_resp_valid = '0;
    m_req_valid  = any_cand & ~fifo_full & ~flush;
    m_resp_ready = s_resp_ready[head] & ~fifo_empty & ~flush;
    busy         = (~fifo_empty | lock) & ~flush;
    if (!flush) begin
      s_req_ready[grant]  = m_req_ready & ~fifo_full & any_cand;
      s_resp_valid[head]  = m_resp_valid & ~fifo_empty;
    end
  end

  assign m_req_addr  = s_req_addr[int'(grant)*BW_ADDR +: BW_ADDR];
  assign s_resp_data = m_resp_ydata[BW_DATA-1:0];
  assign s_resp_last = last;

  assign push = m_req_valid & m_req_ready;
  assign pop  = m_resp_valid & m_resp_ready & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (clear) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      lock    <= m_req_valid & ~m_req_ready;
      lock_id <= grant;
      if (push) begin
        rr_ptr <= grant_next;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage only; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_dca_lsu_read_arbiter.sv
// Directed bench for dca_lsu_read_arbiter: round-robin, grant lock, FIFO full, routing, backpressure, clear.
module tb_dca_lsu_read_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic [3:0]   s_req_valid;
  logic [3:0]   s_req_ready;
  logic [127:0] s_req_addr;
  logic [3:0]   s_resp_valid;
  logic [3:0]   s_resp_ready;
  logic [31:0]  s_resp_data;
  logic         s_resp_last;
  logic         m_req_valid;
  logic         m_req_ready;
  logic [31:0]  m_req_addr;
  logic         m_resp_valid;
  logic         m_resp_ready;
  logic [32:0]  m_resp_ydata;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dca_lsu_read_arbiter #(
    .NUM_REQ(4), .BW_ADDR(32), .BW_DATA(32), .MAX_OUTSTANDING(4), .BW_BURDEN(1)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_data(s_resp_data), .s_resp_last(s_resp_last),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_ydata(m_resp_ydata),
    .busy(busy)
  );

  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h10;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    s_req_valid  = 4'hF;
    s_resp_ready = 4'hF;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_ydata = {1'b1, 32'h1};
    for (int i = 0; i < 4; i++) s_req_addr[i*32 +: 32] = addr_of(i);

    // Reset held with all inputs active: every output must stay low
    @(negedge clk);
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_s_req_ready", s_req_ready, 0);
    chk("rst_s_resp_valid", s_resp_valid, 0);
    chk("rst_m_resp_ready", m_resp_ready, 0);
    chk("rst_busy", busy, 0);

    next_cycle();
    rst = 1'b0; s_req_valid = 4'h0; m_resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_m_req_valid", m_req_valid, 0);
    chk("idle_busy", busy, 0);

    // Round-robin: all valid, each grant answered with a last beat the next cycle
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      s_req_valid = 4'hF; m_req_ready = 1'b1; m_resp_valid = 1'b1;
      m_resp_ydata = {1'b1, 32'hD0 + 32'(k)};
      @(negedge clk);
      chk("rr_addr", m_req_addr, addr_of(k % 4));
      chk("rr_s_req_ready", s_req_ready, 64'(1) << (k % 4));
      chk("rr_s_resp_valid", s_resp_valid, (k == 0) ? 64'(0) : (64'(1) << ((k - 1) % 4)));
      chk("rr_m_resp_ready", m_resp_ready, (k == 0) ? 0 : 1);
    end
    next_cycle();
    s_req_valid = 4'h0; m_resp_ydata = {1'b1, 32'hD5};
    @(negedge clk);
    chk("rr_drain_route", s_resp_valid, 4'b0001);
    chk("rr_drain_data", s_resp_data, 32'hD5);
    chk("rr_drain_last", s_resp_last, 1);
    next_cycle();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("rr_done_busy", busy, 0);

    // Grant req3 alone so rr_ptr wraps to 0
    next_cycle();
    s_req_valid = 4'b1000; m_req_ready = 1'b1;
    @(negedge clk);
    chk("g3_addr", m_req_addr, addr_of(3));
    chk("g3_s_req_ready", s_req_ready, 4'b1000);

    // Grant lock: req1 stalls, req0 arrives with higher priority but must not steal the grant
    next_cycle();
    s_req_valid = 4'b0010; m_req_ready = 1'b0;
    @(negedge clk);
    chk("lock_a_valid", m_req_valid, 1);
    chk("lock_a_addr", m_req_addr, addr_of(1));
    chk("lock_a_s_req_ready", s_req_ready, 0);
    next_cycle();
    s_req_valid = 4'b0011;
    @(negedge clk);
    chk("lock_b_addr", m_req_addr, addr_of(1));
    chk("lock_b_busy", busy, 1);
    next_cycle();
    @(negedge clk);
    chk("lock_c_addr", m_req_addr, addr_of(1));
    chk("lock_c_s_req_ready", s_req_ready, 0);
    next_cycle();
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("lock_d_addr", m_req_addr, addr_of(1));
    chk("lock_d_s_req_ready", s_req_ready, 4'b0010);
    next_cycle();
    s_req_valid = 4'b0001;
    @(negedge clk);
    chk("after_lock_addr", m_req_addr, addr_of(0));
    chk("after_lock_s_req_ready", s_req_ready, 4'b0001);

    // Fill the FIFO: rr_ptr=1, req0 and req2 valid -> req2 is the fourth entry
    next_cycle();
    s_req_valid = 4'b0101;
    @(negedge clk);
    chk("fill_addr", m_req_addr, addr_of(2));

    // Full with head=3 backpressured by requester 3
    next_cycle();
    m_resp_valid = 1'b1; s_resp_ready = 4'b0111; m_resp_ydata = {1'b1, 32'hBEEF};
    @(negedge clk);
    chk("full_m_req_valid", m_req_valid, 0);
    chk("full_s_req_ready", s_req_ready, 0);
    chk("bp_s_resp_valid", s_resp_valid, 4'b1000);
    chk("bp_m_resp_ready", m_resp_ready, 0);
    chk("bp_data", s_resp_data, 32'hBEEF);
    next_cycle();
    s_resp_ready = 4'hF;
    @(negedge clk);
    chk("bp_release_ready", m_resp_ready, 1);
    chk("bp_release_route", s_resp_valid, 4'b1000);
    chk("pop_cycle_no_grant", m_req_valid, 0);
    next_cycle();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("post_pop_valid", m_req_valid, 1);
    chk("post_pop_addr", m_req_addr, addr_of(0));
    chk("post_pop_s_req_ready", s_req_ready, 4'b0001);

    // Pop head 1, leaving three IDs outstanding
    next_cycle();
    s_req_valid = 4'h0; m_resp_valid = 1'b1; m_resp_ydata = {1'b1, 32'h77};
    @(negedge clk);
    chk("pre_clear_route", s_resp_valid, 4'b0010);

    // Clear mid-operation
    next_cycle();
    clear = 1'b1; s_req_valid = 4'hF; m_req_ready = 1'b1;
    @(negedge clk);
    chk("clr_m_req_valid", m_req_valid, 0);
    chk("clr_s_req_ready", s_req_ready, 0);
    chk("clr_s_resp_valid", s_resp_valid, 0);
    chk("clr_m_resp_ready", m_resp_ready, 0);
    chk("clr_busy", busy, 0);
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    chk("post_clr_busy", busy, 0);
    chk("empty_hold_m_resp_ready", m_resp_ready, 0);
    chk("empty_hold_s_resp_valid", s_resp_valid, 0);
    chk("post_clr_addr", m_req_addr, addr_of(0));
    chk("post_clr_s_req_ready", s_req_ready, 4'b0001);

    // Response routing: grants 0 then 2, beats last=0,1 then 1
    next_cycle();
    s_req_valid = 4'b0100; m_resp_valid = 1'b0;
    @(negedge clk);
    chk("route_grant_addr", m_req_addr, addr_of(2));
    next_cycle();
    s_req_valid = 4'h0; m_resp_valid = 1'b1; m_resp_ydata = {1'b0, 32'h111};
    @(negedge clk);
    chk("route_b0_valid", s_resp_valid, 4'b0001);
    chk("route_b0_last", s_resp_last, 0);
    chk("route_b0_data", s_resp_data, 32'h111);
    next_cycle();
    m_resp_ydata = {1'b1, 32'h222};
    @(negedge clk);
    chk("route_b1_valid", s_resp_valid, 4'b0001);
    chk("route_b1_last", s_resp_last, 1);
    next_cycle();
    m_resp_ydata = {1'b1, 32'h333};
    @(negedge clk);
    chk("route_b2_valid", s_resp_valid, 4'b0100);
    chk("route_b2_data", s_resp_data, 32'h333);
    next_cycle();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("route_done_busy", busy, 0);
    chk("route_done_m_req_valid", m_req_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dca_lsu_read_arbiter.md
Name: dca_lsu_read_arbiter

Overview:
- Shares one LPIXM read-request/read-response port pair among NUM_REQ requesters (DCA matrix load units).
- Grants requests round-robin and records each accepted requester ID in an in-order ID FIFO.
- Returns each response to the requester at the FIFO head, and pops the FIFO on the response beat that carries the last-burden flag.
- Sits between the DCA load units and the single LSU read port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BW_ADDR, 32, request address width.
- BW_DATA, 32, response data width.
- MAX_OUTSTANDING, 4, ID FIFO depth (power of 2, 2..16); maximum number of granted requests without their last response.
- BW_BURDEN, 1, burden field width; the MSB of the burden field is the last flag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush.
- s_req_valid  in  NUM_REQ  per-requester request valid.
- s_req_ready  out  NUM_REQ  per-requester request ready.
- s_req_addr  in  NUM_REQ*BW_ADDR  flattened addresses; requester i occupies [i*BW_ADDR +: BW_ADDR].
- s_resp_valid  out  NUM_REQ  per-requester response valid.
- s_resp_ready  in  NUM_REQ  per-requester response ready.
- s_resp_data  out  BW_DATA  response data, broadcast to all requesters.
- s_resp_last  out  1  last beat of the current response.
- m_req_valid  out  1  shared request valid.
- m_req_ready  in  1  shared request ready.
- m_req_addr  out  BW_ADDR  address of the granted requester.
- m_resp_valid  in  1  shared response valid.
- m_resp_ready  out  1  shared response ready.
- m_resp_ydata  in  BW_DATA+BW_BURDEN  response: {burden, data}.
- busy  out  1  FIFO not empty or grant locked.

Behaviour:
- Reset / clear: clear has the same effect as rst, but synchronously.
  - rr_ptr=0, grant lock=0, FIFO empty, fifo count=0.
  - All outputs 0: m_req_valid, m_resp_ready, every s_req_ready bit, every s_resp_valid bit, busy.
  - No response is forwarded during the clear cycle.
  - Reset or clear mid-operation discards in-flight IDs. The upstream LSU must be drained or reset together with this block.
- Arbitration (request path):
  - Candidates: requesters with s_req_valid=1, searched from rr_ptr upward with wrap-around. The first hit is the grant g.
  - Grant lock: once m_req_valid is asserted for g and not yet accepted, g is held (lock=1) even if higher-priority requests arrive. This keeps valid stable until the handshake.
  - m_req_valid = any candidate & ~fifo_full. m_req_addr = address of g. s_req_ready[g] = m_req_ready & ~fifo_full; all other s_req_ready bits = 0.
  - Request handshake (m_req_valid & m_req_ready): push g into the FIFO, rr_ptr <= (g+1) mod NUM_REQ, lock <= 0.
  - Zero-cycle combinational path from request to m_req; no added latency.
- FIFO full: no grant is issued (m_req_valid=0). A pop in the same cycle does not enable a push; the push waits one cycle. This is deliberately conservative.
- Response path:
  - head = FIFO head ID.
  - s_resp_valid[head] = m_resp_valid & ~fifo_empty; all other bits 0.
  - s_resp_data = m_resp_ydata[BW_DATA-1:0].
  - s_resp_last = m_resp_ydata[BW_DATA+BW_BURDEN-1].
  - m_resp_ready = s_resp_ready[head] & ~fifo_empty.
  - Response handshake with last=1: pop the FIFO. With last=0: the head is kept (multi-beat response).
  - m_resp_valid while the FIFO is empty is a protocol error: the beat is held unaccepted (m_resp_ready=0) and is not dropped.
- Simultaneous push and pop when not full: count stays unchanged, and the pointers advance independently.
- Pointers: read/write pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. Full/empty are derived from a count of width log2(MAX_OUTSTANDING)+1.
- Ordering: responses are strictly in grant order. The LSU is required to return responses in request order.
- busy = ~fifo_empty | lock.

Test Plan:
- Round-robin fairness: NUM_REQ=4, all valid, m_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; addresses match the granting requester.
- Grant lock: req1 valid, m_req_ready=0 for 3 cycles, req0 raised at cycle 2 -> m_req_addr stays at req1's address until accepted; the next grant is req2 if valid, else req0.
- FIFO full: MAX_OUTSTANDING=4, 4 requests granted, no responses -> m_req_valid=0 and s_req_ready=0. One last-beat response -> the next grant follows one cycle after the pop.
- Response routing: grants 2,0; responses with burden last=0,1 then 1 -> first two beats on s_resp_valid[2], third on s_resp_valid[0]; FIFO empty afterwards, busy=0.
- Backpressure: head=3, s_resp_ready[3]=0 with m_resp_valid=1 -> m_resp_ready=0 and the data is held. Raising ready -> one handshake, pop.
- Reset/clear mid-operation: 3 IDs outstanding, assert clear for 1 cycle -> all outputs 0 and count=0; the next grant starts from requester 0.
